// File: rtl/ysyx_22041211_arb_pkg.sv
// Shared types and constants for the IFU/LSU memory arbiter.
// The request struct is sized by the package widths. The arbiter's ADDR_LEN,
// DATA_LEN and MASK_LEN parameters are expected to keep these values.
package ysyx_22041211_arb_pkg;

    localparam int ARB_ADDR_LEN = 32;
    localparam int ARB_DATA_LEN = 32;
    localparam int ARB_MASK_LEN = 8;

    // Instruction fetches are always full-word reads.
    localparam logic [ARB_MASK_LEN-1:0] IFU_WMASK = 8'b00001111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } arb_owner_t;

    typedef struct packed {
        logic [ARB_ADDR_LEN-1:0] addr;
        logic                    wen;
        logic [ARB_DATA_LEN-1:0] wdata;
        logic [ARB_MASK_LEN-1:0] wmask;
    } arb_req_t;

    // Build the latched request for an instruction fetch. A fetch never
    // writes, so wen and wdata are zero and the mask is the fixed fetch mask.
    function automatic arb_req_t ifu_request(input logic [ARB_ADDR_LEN-1:0] addr);
        arb_req_t r;
        r.addr  = addr;
        r.wen   = 1'b0;
        r.wdata = '0;
        r.wmask = IFU_WMASK;
        return r;
    endfunction

endpackage

// File: rtl/ysyx_22041211_arb_pick.sv
// Combinational winner select between the IFU and LSU request lines.
// A grant is raised only while enable is high, and only for a valid requester,
// so a grant is also the handshake for that requester.
// The build option YSYX_22041211_ARB_RR_EN selects round-robin arbitration
// with a last_grant register. Without it, the LSU has fixed priority over the IFU.
module ysyx_22041211_arb_pick (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic ifu_valid,
    input  logic lsu_valid,
    output logic ifu_grant,
    output logic lsu_grant
);
    import ysyx_22041211_arb_pkg::*;

`ifdef YSYX_22041211_ARB_RR_EN
    arb_owner_t last_grant_reg;
    arb_owner_t last_grant_next;
    logic       prefer_ifu;

    // On a tie, the requester that was not served last goes first.
    assign prefer_ifu = (last_grant_reg == OWN_LSU);

    // Grant select and last-grant bookkeeping.
    always_comb begin
        ifu_grant       = 1'b0;
        lsu_grant       = 1'b0;
        last_grant_next = last_grant_reg;
        if (enable) begin
            if (ifu_valid && lsu_valid) begin
                ifu_grant = prefer_ifu;
                lsu_grant = !prefer_ifu;
            end else begin
                ifu_grant = ifu_valid;
                lsu_grant = lsu_valid;
            end
        end
        if (ifu_grant) begin
            last_grant_next = OWN_IFU;
        end else if (lsu_grant) begin
            last_grant_next = OWN_LSU;
        end
    end

    // last_grant resets to LSU, so the IFU wins the first tie.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_grant_reg <= OWN_LSU;
        end else begin
            last_grant_reg <= last_grant_next;
        end
    end
`else
    // Fixed priority holds no state, so the clock and reset are not used.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    // Fixed priority: the LSU beats the IFU.
    always_comb begin
        lsu_grant = enable && lsu_valid;
        ifu_grant = enable && ifu_valid && !lsu_valid;
    end
`endif

endmodule

// File: rtl/ysyx_22041211_mem_arbiter.sv
// Single-port memory arbiter between the IFU (read-only) and the LSU (read/write).
// It allows one outstanding transaction, sequenced IDLE -> REQ -> WAIT -> RESP.
// If memory does not respond in time, the transaction ends with an error response.
// Build option: YSYX_22041211_ARB_RR_EN enables round-robin arbitration in
// ysyx_22041211_arb_pick. Otherwise the LSU has fixed priority.
module ysyx_22041211_mem_arbiter #(
    parameter int ADDR_LEN       = 32,
    parameter int DATA_LEN       = 32,
    parameter int MASK_LEN       = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_LEN-1:0] ifu_addr,
    output logic                ifu_resp_valid,
    output logic [DATA_LEN-1:0] ifu_rdata,
    output logic                ifu_resp_err,

    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_LEN-1:0] lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_LEN-1:0] lsu_wdata,
    input  logic [MASK_LEN-1:0] lsu_wmask,
    output logic                lsu_resp_valid,
    output logic [DATA_LEN-1:0] lsu_rdata,
    output logic                lsu_resp_err,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_LEN-1:0] mem_addr,
    output logic                mem_wen,
    output logic [DATA_LEN-1:0] mem_wdata,
    output logic [MASK_LEN-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_LEN-1:0] mem_rdata
);
    import ysyx_22041211_arb_pkg::*;

    // The counter only has to reach TIMEOUT_CYCLES-1. It is cleared whenever
    // WAIT is left, so it never wraps.
    localparam int             CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    arb_state_t          state_reg, state_next;
    arb_owner_t          owner_reg, owner_next;
    arb_req_t            req_reg, req_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [DATA_LEN-1:0] rdata_reg, rdata_next;
    logic                err_reg, err_next;

    logic                ifu_grant, lsu_grant;
    logic                arb_enable;
    logic [1:0]          resp_valid_vec;

    // Requests are accepted only in IDLE. They are also refused while reset
    // is held, so both ready outputs stay low during reset.
    assign arb_enable = (state_reg == IDLE) && rst;

    ysyx_22041211_arb_pick u_pick (
        .clk       (clk),
        .rst       (rst),
        .enable    (arb_enable),
        .ifu_valid (ifu_req_valid),
        .lsu_valid (lsu_req_valid),
        .ifu_grant (ifu_grant),
        .lsu_grant (lsu_grant)
    );

    assign ifu_req_ready = ifu_grant;
    assign lsu_req_ready = lsu_grant;

    // Next-state logic: latch the request, issue it, then wait for the
    // response or the timeout.
    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        req_next   = req_reg;
        cnt_next   = cnt_reg;
        rdata_next = rdata_reg;
        err_next   = err_reg;

        unique case (state_reg)
            IDLE: begin
                if (lsu_grant) begin
                    owner_next     = OWN_LSU;
                    req_next.addr  = ARB_ADDR_LEN'(lsu_addr);
                    req_next.wen   = lsu_wen;
                    req_next.wdata = ARB_DATA_LEN'(lsu_wdata);
                    req_next.wmask = ARB_MASK_LEN'(lsu_wmask);
                    state_next     = REQ;
                end else if (ifu_grant) begin
                    owner_next = OWN_IFU;
                    req_next   = ifu_request(ARB_ADDR_LEN'(ifu_addr));
                    state_next = REQ;
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    cnt_next   = '0;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                cnt_next = cnt_reg + CNT_ONE;
                // If the response and the timeout land in the same cycle,
                // the response is used.
                if (mem_resp_valid) begin
                    rdata_next = req_reg.wen ? '0 : mem_rdata;
                    err_next   = 1'b0;
                    cnt_next   = '0;
                    state_next = RESP;
                end else if (cnt_reg == CNT_LAST) begin
                    rdata_next = '0;
                    err_next   = 1'b1;
                    cnt_next   = '0;
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset abandons any transaction in flight
    // and gives no response for it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
            owner_reg <= OWN_IFU;
            req_reg   <= '0;
            cnt_reg   <= '0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            req_reg   <= req_next;
            cnt_reg   <= cnt_next;
            rdata_reg <= rdata_next;
            err_reg   <= err_next;
        end
    end

    // The downstream request comes straight from the latched registers, so
    // it holds steady until it is accepted.
    assign mem_req_valid = (state_reg == REQ);
    assign mem_addr      = ADDR_LEN'(req_reg.addr);
    assign mem_wen       = req_reg.wen;
    assign mem_wdata     = DATA_LEN'(req_reg.wdata);
    assign mem_wmask     = MASK_LEN'(req_reg.wmask);

    // Response pulse for the owner only. Index 0 is the IFU and index 1 is the LSU.
    for (genvar gi = 0; gi < 2; gi++) begin : g_resp
        localparam arb_owner_t OWN = (gi == 0) ? OWN_IFU : OWN_LSU;
        assign resp_valid_vec[gi] = (state_reg == RESP) && (owner_reg == OWN);
    end

    assign ifu_resp_valid = resp_valid_vec[0];
    assign lsu_resp_valid = resp_valid_vec[1];
    assign ifu_rdata      = rdata_reg;
    assign lsu_rdata      = rdata_reg;
    assign ifu_resp_err   = err_reg;
    assign lsu_resp_err   = err_reg;

endmodule

// File: tb/tb_ysyx_22041211_mem_arbiter.sv
// Scoreboard bench for ysyx_22041211_mem_arbiter, built with TIMEOUT_CYCLES=4.
// Each transaction pushes its expected response into a queue. A monitor pops
// the queue and compares every response pulse it sees.
module tb_ysyx_22041211_mem_arbiter;

    localparam int TO = 4;
`ifdef YSYX_22041211_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ifu_req_valid = 1'b0, ifu_req_ready;
    logic [31:0] ifu_addr = '0;
    logic        ifu_resp_valid, ifu_resp_err;
    logic [31:0] ifu_rdata;
    logic        lsu_req_valid = 1'b0, lsu_req_ready;
    logic [31:0] lsu_addr = '0;
    logic        lsu_wen = 1'b0;
    logic [31:0] lsu_wdata = '0;
    logic [7:0]  lsu_wmask = '0;
    logic        lsu_resp_valid, lsu_resp_err;
    logic [31:0] lsu_rdata;
    logic        mem_req_valid, mem_wen;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_addr, mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_rdata = '0;

    typedef struct {
        bit          lsu;
        logic [31:0] rdata;
        bit          err;
    } exp_t;

    exp_t exp_q[$];
    int   tests  = 0;
    int   failed = 0;

    always #5 clk = ~clk;

    ysyx_22041211_mem_arbiter #(
        .ADDR_LEN(32), .DATA_LEN(32), .MASK_LEN(8), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata), .lsu_resp_err(lsu_resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every response pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (ifu_resp_valid || lsu_resp_valid) begin
            chk("resp_single_owner", {63'd0, ifu_resp_valid & lsu_resp_valid}, 64'd0);
            if (exp_q.size() == 0) begin
                tests++;
                failed++;
                $display("[TB] FAIL unexpected_resp: got ifu=%0b lsu=%0b, required no pulse at %0t",
                         ifu_resp_valid, lsu_resp_valid, $time);
            end else begin
                e = exp_q.pop_front();
                chk("resp_owner_lsu", {63'd0, lsu_resp_valid}, {63'd0, e.lsu});
                chk("resp_rdata", e.lsu ? lsu_rdata : ifu_rdata, e.rdata);
                chk("resp_err", e.lsu ? lsu_resp_err : ifu_resp_err, e.err);
                $display("[TB] resp owner=%s rdata=0x%08h err=%0b (expected 0x%08h err=%0b)",
                         e.lsu ? "LSU" : "IFU", e.lsu ? lsu_rdata : ifu_rdata,
                         e.lsu ? lsu_resp_err : ifu_resp_err, e.rdata, e.err);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        @(negedge clk);
        chk({tag, "_ifu_ready"}, ifu_req_ready, 0);
        chk({tag, "_lsu_ready"}, lsu_req_ready, 0);
        chk({tag, "_mem_req_valid"}, mem_req_valid, 0);
        chk({tag, "_resp_valid"}, {ifu_resp_valid, lsu_resp_valid}, 0);
        chk({tag, "_rdata"}, {ifu_rdata, lsu_rdata}, 0);
        chk({tag, "_err"}, {ifu_resp_err, lsu_resp_err}, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wen"}, mem_wen, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_mem_wmask"}, mem_wmask, 0);
    endtask

    // Raise one request and expect it to be accepted in the same cycle.
    task automatic request(input bit lsu, input logic [31:0] addr, input bit wen,
                           input logic [31:0] wdata, input logic [7:0] wmask);
        if (lsu) begin
            lsu_req_valid = 1'b1; lsu_addr = addr; lsu_wen = wen;
            lsu_wdata = wdata; lsu_wmask = wmask;
        end else begin
            ifu_req_valid = 1'b1; ifu_addr = addr;
        end
        @(negedge clk);
        chk(lsu ? "lsu_req_ready" : "ifu_req_ready", lsu ? lsu_req_ready : ifu_req_ready, 1);
        tick();
        if (lsu) lsu_req_valid = 1'b0; else ifu_req_valid = 1'b0;
    endtask

    // Play the memory side of an accepted transaction. The task starts in REQ.
    // req_delay:  cycles mem_req_ready stays low.
    // resp_delay: WAIT cycles before the response; a negative value means no
    //             response, so the transaction times out.
    task automatic serve(input bit lsu, input logic [31:0] addr, input bit wen,
                         input logic [31:0] wdata, input logic [7:0] wmask,
                         input int req_delay, input int resp_delay,
                         input logic [31:0] mem_data, input bit late);
        exp_t e;
        int   n;
        e.lsu   = lsu;
        e.err   = (resp_delay < 0);
        e.rdata = ((resp_delay < 0) || (lsu && wen)) ? 32'h0 : mem_data;
        exp_q.push_back(e);
        for (int i = 0; i <= req_delay; i++) begin
            mem_req_ready = (i == req_delay);
            @(negedge clk);
            chk("mem_req_valid", mem_req_valid, 1);
            chk("mem_addr", mem_addr, addr);
            chk("mem_wen", mem_wen, lsu ? wen : 1'b0);
            chk("mem_wmask", mem_wmask, lsu ? wmask : 8'h0F);
            if (lsu) chk("mem_wdata", mem_wdata, wdata);
            chk("no_accept_in_req", {ifu_req_ready, lsu_req_ready}, 0);
            tick();
        end
        mem_req_ready = 1'b0;
        n = (resp_delay < 0) ? TO : resp_delay;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("wait_no_mem_req", mem_req_valid, 0);
            chk("wait_no_early_resp", {ifu_resp_valid, lsu_resp_valid}, 0);
            chk("no_accept_in_wait", {ifu_req_ready, lsu_req_ready}, 0);
            tick();
        end
        if (resp_delay >= 0) begin
            mem_resp_valid = 1'b1;
            mem_rdata      = mem_data;
            tick();
            mem_resp_valid = 1'b0;
        end
        @(negedge clk);
        chk("resp_latency", lsu ? lsu_resp_valid : ifu_resp_valid, 1);
        chk("no_accept_in_resp", {ifu_req_ready, lsu_req_ready}, 0);
        if (late) begin
            mem_resp_valid = 1'b1;
            mem_rdata      = 32'hBADBAD00;
        end
        tick();
        mem_resp_valid = 1'b0;
        if (late) begin
            for (int i = 0; i < 2; i++) begin
                @(negedge clk);
                chk("late_resp_dropped", {ifu_resp_valid, lsu_resp_valid}, 0);
                tick();
            end
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b1;
        tick();

        // IFU only: response one cycle after acceptance
        request(1'b0, 32'h8000_0000, 1'b0, 32'h0, 8'h00);
        serve(1'b0, 32'h8000_0000, 1'b0, 32'h0, 8'h00, 0, 0, 32'h0010_0093, 1'b0);

        // Simultaneous IFU and LSU reads of the same address
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_1000;
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_1000; lsu_wen = 1'b0; lsu_wmask = 8'hFF;
        @(negedge clk);
        chk("tie_lsu_ready", lsu_req_ready, RR ? 1'b0 : 1'b1);
        chk("tie_ifu_ready", ifu_req_ready, RR ? 1'b1 : 1'b0);
        tick();
        if (RR) begin
            ifu_req_valid = 1'b0;
            serve(1'b0, 32'h8000_1000, 1'b0, 32'h0, 8'h00, 0, 0, 32'h2222_2222, 1'b0);
            @(negedge clk);
            chk("tie_second_lsu_ready", lsu_req_ready, 1);
            tick();
            lsu_req_valid = 1'b0;
            serve(1'b1, 32'h8000_1000, 1'b0, 32'h0, 8'hFF, 0, 0, 32'h1111_1111, 1'b0);
        end else begin
            lsu_req_valid = 1'b0;
            serve(1'b1, 32'h8000_1000, 1'b0, 32'h0, 8'hFF, 0, 0, 32'h1111_1111, 1'b0);
            @(negedge clk);
            chk("tie_second_ifu_ready", ifu_req_ready, 1);
            tick();
            ifu_req_valid = 1'b0;
            serve(1'b0, 32'h8000_1000, 1'b0, 32'h0, 8'h00, 0, 0, 32'h2222_2222, 1'b0);
        end

        // LSU write, mem_req_ready held low for 3 cycles, read data must be 0
        request(1'b1, 32'h8000_2000, 1'b1, 32'hDEAD_BEEF, 8'h03);
        serve(1'b1, 32'h8000_2000, 1'b1, 32'hDEAD_BEEF, 8'h03, 3, 1, 32'h1234_5678, 1'b0);

        // LSU read that times out, followed by a late response that must be dropped
        request(1'b1, 32'h8000_3000, 1'b0, 32'h0, 8'h0F);
        serve(1'b1, 32'h8000_3000, 1'b0, 32'h0, 8'h0F, 0, -1, 32'h0, 1'b1);

        // Response in the same cycle as the timeout: the response wins
        request(1'b1, 32'h8000_3004, 1'b0, 32'h0, 8'h0F);
        serve(1'b1, 32'h8000_3004, 1'b0, 32'h0, 8'h0F, 0, TO - 1, 32'hCAFE_F00D, 1'b0);

        // Reset during WAIT abandons the transaction with no response
        request(1'b0, 32'h8000_0010, 1'b0, 32'h0, 8'h00);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        rst = 1'b0;
        tick();
        check_all_zero("midreset");
        rst = 1'b1;
        mem_resp_valid = 1'b1;
        mem_rdata = 32'h5555_AAAA;
        tick();
        mem_resp_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("post_reset_no_resp", {ifu_resp_valid, lsu_resp_valid}, 0);
            chk("post_reset_no_mem_req", mem_req_valid, 0);
            tick();
        end

        // The next IFU request completes normally
        request(1'b0, 32'h8000_0004, 1'b0, 32'h0, 8'h00);
        serve(1'b0, 32'h8000_0004, 1'b0, 32'h0, 8'h00, 0, 0, 32'h0020_0113, 1'b0);

        repeat (3) tick();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/ysyx_22041211_mem_arbiter.md
Name: ysyx_22041211_mem_arbiter

Overview:
Shares the single physical memory port between the instruction-fetch requester (IFU, read-only) and the load/store requester (LSU, read/write). It replaces the direct per-stage pmem calls with a sequenced, one-outstanding-transaction controller using valid/ready request handshakes. It sits between the core stages and the memory/DPI bridge, and adds a response timeout so a hung memory reports an error instead of stalling the core forever.

Parameters:
ADDR_LEN, 32, address width
DATA_LEN, 32, data width
MASK_LEN, 8, write/read byte-mask width
TIMEOUT_CYCLES, 255, maximum WAIT cycles before an error response; valid range 1..65535

Ports:
clk  input  1  clock; all logic is on the rising edge
rst  input  1  synchronous, active-low reset (rst==0 sampled at posedge resets the block)
ifu_req_valid  input  1  IFU read request
ifu_req_ready  output  1  IFU request accepted this cycle
ifu_addr  input  ADDR_LEN  IFU read address
ifu_resp_valid  output  1  one-cycle IFU response pulse
ifu_rdata  output  DATA_LEN  IFU read data
ifu_resp_err  output  1  IFU response is a timeout error
lsu_req_valid  input  1  LSU request
lsu_req_ready  output  1  LSU request accepted this cycle
lsu_addr  input  ADDR_LEN  LSU address
lsu_wen  input  1  1=write, 0=read
lsu_wdata  input  DATA_LEN  LSU write data
lsu_wmask  input  MASK_LEN  LSU byte mask
lsu_resp_valid  output  1  one-cycle LSU response pulse (read data or write ack)
lsu_rdata  output  DATA_LEN  LSU read data; 0 for writes
lsu_resp_err  output  1  LSU response is a timeout error
mem_req_valid  output  1  downstream request
mem_req_ready  input  1  downstream accepts the request
mem_addr  output  ADDR_LEN  downstream address
mem_wen  output  1  downstream write enable
mem_wdata  output  DATA_LEN  downstream write data
mem_wmask  output  MASK_LEN  downstream mask; IFU requests drive 8'b00001111
mem_resp_valid  input  1  downstream response
mem_rdata  input  DATA_LEN  downstream read data

Behaviour:
- FSM states: IDLE, REQ, WAIT, RESP. At most one transaction is outstanding.
- IDLE:
  - Arbitration is combinational. xxx_req_ready=1 only for the winner, and only in IDLE.
  - Default fixed priority: LSU beats IFU.
  - On handshake (valid&ready): latch owner, addr, wen, wdata, mask into registers; go to REQ.
  - IFU transactions force wen=0 and mask=8'b00001111.
- REQ:
  - mem_req_valid=1; all mem_* outputs come from the latched registers and are stable until accepted.
  - On mem_req_ready=1: go to WAIT and clear the timeout counter.
- WAIT:
  - mem_req_valid=0; the counter increments every cycle.
  - If mem_resp_valid=1: capture mem_rdata (forced to 0 if wen), err=0, go to RESP.
  - Otherwise, when counter==TIMEOUT_CYCLES-1: rdata=0, err=1, go to RESP.
  - If mem_resp_valid arrives in the same cycle as the timeout, the response wins (err=0).
- RESP:
  - The owner's resp_valid=1 for exactly one cycle, with registered rdata/err; the other requester's resp_valid stays 0.
  - Next state is IDLE. No request is accepted in RESP.
- mem_resp_valid is ignored in IDLE, REQ and RESP. Late responses after a timeout are dropped.
- Minimum latency (mem_req_ready=1 and response one cycle later): handshake at cycle N, mem_req_valid at N+1, WAIT at N+2 with response, resp_valid at N+3. The back-to-back issue rate is one transaction per 4 cycles minimum.
- Requesters hold valid and payload until ready is seen. The block has no resp_ready input; requesters must accept the response pulse.
- Reset:
  - State returns to IDLE; owner=IFU; counter=0.
  - All outputs drive 0: *_ready, mem_req_valid, resp_valid, rdata, err, and all mem_* outputs.
  - Reset mid-transaction abandons it with no response; any subsequent mem_resp_valid is ignored.
- Counter width is $clog2(TIMEOUT_CYCLES+1); it never wraps, because it is cleared on leaving WAIT.

Optional Feature:
- Macro: YSYX_22041211_ARB_RR_EN.
- Defined: round-robin arbitration. A last_grant register (reset value LSU, so IFU wins the first tie) updates on every handshake. On simultaneous valids the requester not granted last wins.
- Undefined: fixed LSU-over-IFU priority with no last_grant register.
- Single-requester behaviour is identical in both builds.

Decomposition:
- Shared package ysyx_22041211_arb_pkg: state enum (IDLE/REQ/WAIT/RESP), owner enum (OWN_IFU/OWN_LSU), constant IFU_WMASK=8'b00001111, and a packed request struct {addr, wen, wdata, wmask}.
- One natural sub-module: ysyx_22041211_arb_pick, the combinational winner select with the optional last_grant register. The FSM, timer and response registers stay in the top module.

Test Plan:
- IFU only: ifu_addr=0x80000000 with mem_req_ready=1 and response one cycle later with 0x00100093 -> ifu_resp_valid at handshake+3, ifu_rdata=0x00100093, err=0, mem_wmask=0x0F.
- Simultaneous IFU and LSU read 0x80001000 -> default build: LSU granted first, IFU granted in the next IDLE; RR_EN build: IFU first (reset tie), then LSU; responses routed to the correct owner only.
- LSU write: addr=0x80002000, wdata=0xDEADBEEF, wmask=0x03, mem_req_ready delayed 3 cycles -> mem_* held stable for all 3 cycles; lsu_resp_valid with rdata=0, err=0.
- Timeout with TIMEOUT_CYCLES=4 and no mem_resp_valid -> lsu_resp_valid 4 cycles after entering WAIT, err=1, rdata=0; a late mem_resp_valid one cycle later is ignored (no second pulse).
- Response and timeout in the same cycle -> err=0 and data taken from mem_rdata.
- rst=0 asserted during WAIT -> all outputs 0 next cycle, no resp_valid; a following mem_resp_valid is ignored; the next IFU request completes normally.
